// File: rtl/sdb_pkg.sv
// sdb_pkg: shared state encoding and widths for the sensor debouncer (optional SDB_GLITCH_CNT_EN glitch counters)
package sdb_pkg;
  typedef enum logic [1:0] {
    ZERO  = 2'b00,
    WAIT1 = 2'b01,
    ONE   = 2'b10,
    WAIT0 = 2'b11
  } db_state_e;
  localparam int DEFAULT_CNT_W = 20;
  localparam int GLITCH_W = 8;
  // Debounced level is 1 in ONE and WAIT0, i.e. the state's upper bit
  function automatic logic level_of(input db_state_e s);
    return s[1];
  endfunction
endpackage

// File: rtl/db_channel.sv
// db_channel: one channel's 2-FF synchroniser, stable-time debounce FSM and optional glitch counter (SDB_GLITCH_CNT_EN)
module db_channel
  import sdb_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_in,
  output logic db_level,
  output logic rise_tick,
  output logic fall_tick
`ifdef SDB_GLITCH_CNT_EN
  ,
  output logic [GLITCH_W-1:0] glitch_cnt
`endif
);
  logic sync1_q, sync1_d, sync_out_q, sync_out_d;
  db_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic rise_q, rise_d, fall_q, fall_d;
  // Synchroniser feed: two flops in series before the FSM sees the input
  always_comb begin
    sync1_d = raw_in;
    sync_out_d = sync1_q;
  end
  // Debounce FSM: a WAIT state completes only after the counter drains with the input steady
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    case (state_q)
      ZERO: if (sync_out_q) begin
        state_d = WAIT1;
        cnt_d = '1;
      end
      WAIT1: if (!sync_out_q) state_d = ZERO;
        else if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        else begin
          state_d = ONE;
          rise_d = 1'b1;
        end
      ONE: if (!sync_out_q) begin
        state_d = WAIT0;
        cnt_d = '1;
      end
      WAIT0: if (sync_out_q) state_d = ONE;
        else if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        else begin
          state_d = ZERO;
          fall_d = 1'b1;
        end
      default: state_d = ZERO;
    endcase
  end
  // State, counter, synchroniser and tick registers; reset clears everything at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync_out_q <= 1'b0;
      state_q <= ZERO;
      cnt_q <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync_out_q <= sync_out_d;
      state_q <= state_d;
      cnt_q <= cnt_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end
  assign db_level = level_of(state_q);
  assign rise_tick = rise_q;
  assign fall_tick = fall_q;
`ifdef SDB_GLITCH_CNT_EN
  logic abort;
  logic [GLITCH_W-1:0] glitch_q, glitch_d;
  // A wait aborted back to the previous stable state counts as one glitch, saturating at all-ones
  always_comb begin
    abort = (state_q == WAIT1 && !sync_out_q) || (state_q == WAIT0 && sync_out_q);
    glitch_d = (abort && glitch_q != '1) ? glitch_q + 1'b1 : glitch_q;
  end
  // Glitch counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) glitch_q <= '0;
    else glitch_q <= glitch_d;
  end
  assign glitch_cnt = glitch_q;
`endif
endmodule

// File: rtl/sensor_debouncer.sv
// sensor_debouncer: N_CH independent debounced sensor channels (optional SDB_GLITCH_CNT_EN adds glitch_cnt)
module sensor_debouncer
  import sdb_pkg::*;
#(
  parameter int N_CH = 2,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] raw_in,
  output logic [N_CH-1:0] db_level,
  output logic [N_CH-1:0] rise_tick,
  output logic [N_CH-1:0] fall_tick
`ifdef SDB_GLITCH_CNT_EN
  ,
  output logic [GLITCH_W*N_CH-1:0] glitch_cnt
`endif
);
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    db_channel #(.CNT_W(CNT_W)) u_ch (
      .clk       (clk),
      .reset     (reset),
      .raw_in    (raw_in[i]),
      .db_level  (db_level[i]),
      .rise_tick (rise_tick[i]),
      .fall_tick (fall_tick[i])
`ifdef SDB_GLITCH_CNT_EN
      ,
      .glitch_cnt(glitch_cnt[GLITCH_W*i +: GLITCH_W])
`endif
    );
  end
endmodule

// File: tb/tb_sensor_debouncer.sv
// tb_sensor_debouncer: directed table and corner-case sequences for sensor_debouncer with CNT_W=3
module tb_sensor_debouncer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0] raw_in = 2'b00;
  logic [1:0] db_level, rise_tick, fall_tick;
`ifdef SDB_GLITCH_CNT_EN
  logic [15:0] glitch_cnt;
`endif
  int passed = 0;
  int total = 0;

  sensor_debouncer #(.N_CH(2), .CNT_W(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .raw_in   (raw_in),
    .db_level (db_level),
    .rise_tick(rise_tick),
    .fall_tick(fall_tick)
`ifdef SDB_GLITCH_CNT_EN
    ,
    .glitch_cnt(glitch_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] raw;
    logic [1:0] lvl;
    logic [1:0] rise;
    logic [1:0] fall;
  } vec_t;
  vec_t tbl[64];
  int n_vec = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic add(input logic [1:0] raw, input logic [1:0] lvl, input logic [1:0] rise,
                     input logic [1:0] fall, input int n);
    for (int k = 0; k < n; k++) begin
      tbl[n_vec] = '{raw, lvl, rise, fall};
      n_vec++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chk("tick_exclusive", {30'd0, rise_tick & fall_tick}, 32'd0);
  endtask

  initial begin
    int first_rise;
    int n_rise;
    // clean rise ch0, glitch ch1, rise ch1, fall ch1 (edge 0 = first edge sampling the new value)
    add(2'b01, 2'b00, 2'b00, 2'b00, 10);
    add(2'b01, 2'b01, 2'b01, 2'b00, 1);
    add(2'b01, 2'b01, 2'b00, 2'b00, 3);
    add(2'b11, 2'b01, 2'b00, 2'b00, 4);
    add(2'b01, 2'b01, 2'b00, 2'b00, 12);
    add(2'b11, 2'b01, 2'b00, 2'b00, 10);
    add(2'b11, 2'b11, 2'b10, 2'b00, 1);
    add(2'b11, 2'b11, 2'b00, 2'b00, 2);
    add(2'b01, 2'b11, 2'b00, 2'b00, 10);
    add(2'b01, 2'b01, 2'b00, 2'b10, 1);
    add(2'b01, 2'b01, 2'b00, 2'b00, 2);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {26'd0, db_level, rise_tick, fall_tick}, 32'd0);
    reset = 1'b0;

    for (int v = 0; v < n_vec; v++) begin
      raw_in = tbl[v].raw;
      tick();
      chk($sformatf("vec%0d", v), {26'd0, db_level, rise_tick, fall_tick},
          {26'd0, tbl[v].lvl, tbl[v].rise, tbl[v].fall});
    end
`ifdef SDB_GLITCH_CNT_EN
    chk("glitch_ch1", {24'd0, glitch_cnt[15:8]}, 32'd1);
    chk("glitch_ch0", {24'd0, glitch_cnt[7:0]}, 32'd0);
`endif

    // asynchronous reset mid-wait with both inputs high
    raw_in = 2'b11;
    repeat (6) tick();
    #2 reset = 1'b1;
    #1;
    chk("async_reset", {26'd0, db_level, rise_tick, fall_tick}, 32'd0);
    tick();
    tick();
    chk("reset_hold", {26'd0, db_level, rise_tick, fall_tick}, 32'd0);
    reset = 1'b0;
    for (int e = 0; e < 10; e++) tick();
    chk("rst_rel_e9", {30'd0, db_level}, 32'd0);
    tick();
    chk("rst_rel_e10", {28'd0, db_level, rise_tick}, {28'd0, 2'b11, 2'b11});
    tick();
    chk("rst_rel_e11", {28'd0, db_level, rise_tick}, {28'd0, 2'b11, 2'b00});

    // both channels fall together
    raw_in = 2'b00;
    for (int e = 0; e < 10; e++) tick();
    chk("fall_e9", {28'd0, db_level, fall_tick}, {28'd0, 2'b11, 2'b00});
    tick();
    chk("fall_e10", {28'd0, db_level, fall_tick}, {28'd0, 2'b00, 2'b11});
    tick();
    chk("fall_e11", {28'd0, db_level, fall_tick}, {28'd0, 2'b00, 2'b00});

    // bounce on ch0: toggle every 3 cycles for 30 cycles, then hold high
    n_rise = 0;
    for (int c = 0; c < 30; c++) begin
      raw_in = {1'b0, ((c / 3) % 2 == 0)};
      tick();
      n_rise += int'(rise_tick[0]);
    end
    chk("bounce_no_rise", n_rise, 0);
    chk("bounce_level", {30'd0, db_level}, 32'd0);
    raw_in = 2'b01;
    first_rise = -1;
    n_rise = 0;
    for (int e = 0; e < 20; e++) begin
      tick();
      if (rise_tick[0]) begin
        n_rise++;
        if (first_rise < 0) first_rise = e;
      end
    end
    chk("bounce_rise_edge", first_rise, 10);
    chk("bounce_rise_count", n_rise, 1);
    chk("bounce_final", {30'd0, db_level}, 32'd1);
`ifdef SDB_GLITCH_CNT_EN
    chk("bounce_glitches", {24'd0, glitch_cnt[7:0]}, 32'd5);
`endif

    // 300 short low excursions on ch0 while it is stable high
    for (int g = 0; g < 300; g++) begin
      raw_in = 2'b00;
      repeat (3) tick();
      raw_in = 2'b01;
      repeat (3) tick();
`ifdef SDB_GLITCH_CNT_EN
      if (g == 99) chk("glitch_105", {24'd0, glitch_cnt[7:0]}, 32'd105);
`endif
    end
    repeat (4) tick();
    chk("sat_level", {30'd0, db_level}, 32'd1);
`ifdef SDB_GLITCH_CNT_EN
    chk("glitch_sat", {24'd0, glitch_cnt[7:0]}, 32'd255);
    chk("glitch_ch1_zero", {24'd0, glitch_cnt[15:8]}, 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
